// File: rtl/vdp_stream_pkg.sv
// Shared constants for the pixel-stream demux: FSM state encoding and route IDs.
package vdp_stream_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam logic ROUTE_0 = 1'b0;
    localparam logic ROUTE_1 = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY
    } state_e;

endpackage

// File: rtl/stream_out_stage_nbits.sv
// One output register slice (valid/data/last) plus its delivered-packet counter.
module stream_out_stage_nbits #(
    parameter int bits     = 2,
    parameter int cnt_bits = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [bits-1:0]     data_i,
    input  logic                last_i,
    input  logic                out_ready_i,
    output logic                can_load_o,
    output logic                out_valid_o,
    output logic [bits-1:0]     out_data_o,
    output logic                out_last_o,
    output logic [cnt_bits-1:0] pkt_cnt_o
);

    localparam logic [cnt_bits-1:0] CNT_ONE = 1;

    logic                valid_q;
    logic [bits-1:0]     data_q;
    logic                last_q;
    logic [cnt_bits-1:0] cnt_q;
    logic                drain;

    assign drain      = valid_q & out_ready_i;
    assign can_load_o = ~valid_q | out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    // Counts on the handshake of the last word, so a packet counts once it is fully delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (drain && last_q) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign pkt_cnt_o   = cnt_q;

endmodule

// File: rtl/stream_demux_1x2_nbits.sv
// 1-to-2 stream demux: route locks on a packet's first word and holds until its last word.
module stream_demux_1x2_nbits
    import vdp_stream_pkg::*;
#(
    parameter int bits     = 2,
    parameter int cnt_bits = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bits-1:0]     in_data,
    input  logic                in_last,
    output logic                out_valid_0,
    output logic                out_valid_1,
    input  logic                out_ready_0,
    input  logic                out_ready_1,
    output logic [bits-1:0]     out_data_0,
    output logic [bits-1:0]     out_data_1,
    output logic                out_last_0,
    output logic                out_last_1,
    output logic [cnt_bits-1:0] pkt_cnt_0,
    output logic [cnt_bits-1:0] pkt_cnt_1
);

    state_e state_q, state_d;
    logic   route_q, route_d;
    logic   route;
    logic   accept;
    logic   can_load_0, can_load_1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            route_q <= ROUTE_0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    assign route = (state_q == S_BUSY) ? route_q : sel;

    // Only the selected stage gates the input; the other one may stall freely.
    assign in_ready = (route == ROUTE_1) ? can_load_1 : can_load_0;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        if (accept) begin
            case (state_q)
                S_IDLE: if (!in_last) begin
                    state_d = S_BUSY;
                    route_d = sel;
                end
                S_BUSY: if (in_last) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    stream_out_stage_nbits #(.bits(bits), .cnt_bits(cnt_bits)) u_stage_0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept && (route == ROUTE_0)),
        .data_i      (in_data),
        .last_i      (in_last),
        .out_ready_i (out_ready_0),
        .can_load_o  (can_load_0),
        .out_valid_o (out_valid_0),
        .out_data_o  (out_data_0),
        .out_last_o  (out_last_0),
        .pkt_cnt_o   (pkt_cnt_0)
    );

    stream_out_stage_nbits #(.bits(bits), .cnt_bits(cnt_bits)) u_stage_1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept && (route == ROUTE_1)),
        .data_i      (in_data),
        .last_i      (in_last),
        .out_ready_i (out_ready_1),
        .can_load_o  (can_load_1),
        .out_valid_o (out_valid_1),
        .out_data_o  (out_data_1),
        .out_last_o  (out_last_1),
        .pkt_cnt_o   (pkt_cnt_1)
    );

endmodule

// File: tb/tb_stream_demux_1x2_nbits.sv
// Directed bench for stream_demux_1x2_nbits (bits=8, cnt_bits=2 so counter wrap is reachable).
module tb_stream_demux_1x2_nbits;

    localparam int BITS = 8;
    localparam int CB   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sel = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BITS-1:0] in_data = '0;
    logic            in_last = 1'b0;
    logic            out_valid_0, out_valid_1;
    logic            out_ready_0 = 1'b0, out_ready_1 = 1'b0;
    logic [BITS-1:0] out_data_0, out_data_1;
    logic            out_last_0, out_last_1;
    logic [CB-1:0]   pkt_cnt_0, pkt_cnt_1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    stream_demux_1x2_nbits #(.bits(BITS), .cnt_bits(CB)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid_0(out_valid_0), .out_valid_1(out_valid_1),
        .out_ready_0(out_ready_0), .out_ready_1(out_ready_1),
        .out_data_0(out_data_0), .out_data_1(out_data_1),
        .out_last_0(out_last_0), .out_last_1(out_last_1),
        .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        out_ready_0 = 1'b0;
        out_ready_1 = 1'b0;
        do_reset();
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if ({out_valid_0, out_valid_1, out_last_0, out_last_1} !== 4'b0000)
            $display("FAIL reset_valid_last got %b want 0000", {out_valid_0, out_valid_1, out_last_0, out_last_1});
        else passed++;
        total++; if ({out_data_0, out_data_1} !== 16'h0000)
            $display("FAIL reset_data got %h want 0000", {out_data_0, out_data_1}); else passed++;
        total++; if ({pkt_cnt_0, pkt_cnt_1} !== 4'b0000)
            $display("FAIL reset_cnt got %b want 0000", {pkt_cnt_0, pkt_cnt_1}); else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        sel = 1'b1; out_ready_0 = 1'b1; out_ready_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'h11 + 8'(i); in_last = (i == 3);
            #1;
            total++; if (in_ready !== 1'b1) $display("FAIL basic_ready[%0d] got %b want 1", i, in_ready); else passed++;
            tick();
            total++; if (out_valid_1 !== 1'b1 || out_data_1 !== 8'h11 + 8'(i) || out_last_1 !== (i == 3))
                $display("FAIL basic_out1[%0d] got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         i, out_valid_1, out_data_1, out_last_1, 8'h11 + 8'(i), (i == 3));
            else passed++;
            total++; if (out_valid_0 !== 1'b0) $display("FAIL basic_out0_idle[%0d] got %b want 0", i, out_valid_0); else passed++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        total++; if (out_valid_1 !== 1'b0 || pkt_cnt_1 !== 2'd1 || pkt_cnt_0 !== 2'd0)
            $display("FAIL basic_done got v1=%b c1=%0d c0=%0d want v1=0 c1=1 c0=0", out_valid_1, pkt_cnt_1, pkt_cnt_0);
        else passed++;
    endtask

    task automatic test_route_lock();
        do_reset();
        sel = 1'b1; out_ready_0 = 1'b1; out_ready_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) sel = 1'b0;
            in_valid = 1'b1; in_data = 8'h21 + 8'(i); in_last = (i == 3);
            tick();
            total++; if (out_valid_1 !== 1'b1 || out_data_1 !== 8'h21 + 8'(i) || out_valid_0 !== 1'b0)
                $display("FAIL lock_word[%0d] got v1=%b d1=%h v0=%b want v1=1 d1=%h v0=0",
                         i, out_valid_1, out_data_1, out_valid_0, 8'h21 + 8'(i));
            else passed++;
        end
        in_data = 8'h30; in_last = 1'b1;
        tick();
        total++; if (out_valid_0 !== 1'b1 || out_data_0 !== 8'h30 || out_last_0 !== 1'b1 || out_valid_1 !== 1'b0)
            $display("FAIL lock_next_pkt got v0=%b d0=%h l0=%b v1=%b want v0=1 d0=30 l0=1 v1=0",
                     out_valid_0, out_data_0, out_last_0, out_valid_1);
        else passed++;
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        total++; if (pkt_cnt_0 !== 2'd1 || pkt_cnt_1 !== 2'd1)
            $display("FAIL lock_cnt got c0=%0d c1=%0d want 1 1", pkt_cnt_0, pkt_cnt_1); else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        sel = 1'b0; out_ready_0 = 1'b0; out_ready_1 = 1'b1;
        in_valid = 1'b1; in_data = 8'h41; in_last = 1'b0;
        tick();
        in_data = 8'h42;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_drop got %b want 0", in_ready); else passed++;
        tick();
        tick();
        total++; if (out_valid_0 !== 1'b1 || out_data_0 !== 8'h41 || in_ready !== 1'b0)
            $display("FAIL bp_hold got v=%b d=%h rdy=%b want v=1 d=41 rdy=0", out_valid_0, out_data_0, in_ready);
        else passed++;
        out_ready_0 = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_resume got %b want 1", in_ready); else passed++;
        tick();
        total++; if (out_valid_0 !== 1'b1 || out_data_0 !== 8'h42 || out_last_0 !== 1'b0)
            $display("FAIL bp_word2 got v=%b d=%h l=%b want v=1 d=42 l=0", out_valid_0, out_data_0, out_last_0);
        else passed++;
        in_data = 8'h43; in_last = 1'b1;
        tick();
        total++; if (out_valid_0 !== 1'b1 || out_data_0 !== 8'h43 || out_last_0 !== 1'b1)
            $display("FAIL bp_word3 got v=%b d=%h l=%b want v=1 d=43 l=1", out_valid_0, out_data_0, out_last_0);
        else passed++;
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        total++; if (out_valid_0 !== 1'b0 || pkt_cnt_0 !== 2'd1 || out_valid_1 !== 1'b0)
            $display("FAIL bp_done got v0=%b c0=%0d v1=%b want 0 1 0", out_valid_0, pkt_cnt_0, out_valid_1);
        else passed++;
    endtask

    task automatic test_wrap_bypass();
        logic [CB-1:0] exp_cnt [5];
        exp_cnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        out_ready_0 = 1'b1; out_ready_1 = 1'b0;
        sel = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
        tick();
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h60 + 8'(i); in_last = 1'b1;
            #1;
            total++; if (in_ready !== 1'b1) $display("FAIL wrap_ready[%0d] got %b want 1", i, in_ready); else passed++;
            tick();
            total++; if (out_valid_0 !== 1'b1 || out_data_0 !== 8'h60 + 8'(i) || pkt_cnt_0 !== exp_cnt[i])
                $display("FAIL wrap_pkt[%0d] got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                         i, out_valid_0, out_data_0, pkt_cnt_0, 8'h60 + 8'(i), exp_cnt[i]);
            else passed++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        total++; if (pkt_cnt_0 !== 2'd1) $display("FAIL wrap_final got %0d want 1", pkt_cnt_0); else passed++;
        total++; if (out_valid_1 !== 1'b1 || out_data_1 !== 8'h55 || pkt_cnt_1 !== 2'd0)
            $display("FAIL wrap_stall1 got v1=%b d1=%h c1=%0d want 1 55 0", out_valid_1, out_data_1, pkt_cnt_1);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        sel = 1'b1; out_ready_0 = 1'b1; out_ready_1 = 1'b0;
        in_valid = 1'b1; in_data = 8'h71; in_last = 1'b0;
        tick();
        in_data = 8'h72;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid_1 !== 1'b0 || out_valid_0 !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midrst_clear got v0=%b v1=%b rdy=%b want 0 0 1", out_valid_0, out_valid_1, in_ready);
        else passed++;
        tick();
        rst_n = 1'b1;
        sel = 1'b0; in_valid = 1'b1; in_data = 8'h80; in_last = 1'b1;
        tick();
        total++; if (out_valid_0 !== 1'b1 || out_data_0 !== 8'h80 || out_valid_1 !== 1'b0)
            $display("FAIL midrst_next got v0=%b d0=%h v1=%b want 1 80 0", out_valid_0, out_data_0, out_valid_1);
        else passed++;
        in_valid = 1'b0; in_last = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_route_lock();
        test_backpressure();
        test_wrap_bypass();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stream_demux_1x2_nbits.md
# stream_demux_1x2_nbits

Registered 1-to-2 pixel-stream demultiplexer with valid/ready handshaking on every port. One incoming stream of `bits`-wide words is routed to one of two downstream consumers, such as ping-pong line buffers or two display pipes. A packet is a run of words ending in a word with `in_last` set, for example one video line. The route is latched on the first word of a packet and held until the packet's last word is accepted, so a packet is never split between outputs.

## Interface
- `bits`, default 2: data word width.
- `cnt_bits`, default 16: width of each per-output packet counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sel`  in  1  route request; 0 selects output 0, 1 selects output 1. Sampled only on a packet's first word.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when `in_valid & in_ready`.
- `in_data`  in  `bits`  input word.
- `in_last`  in  1  marks the final word of a packet.
- `out_valid_0`, `out_valid_1`  out  1 each  output word valid.
- `out_ready_0`, `out_ready_1`  in  1 each  downstream ready.
- `out_data_0`, `out_data_1`  out  `bits` each  output word.
- `out_last_0`, `out_last_1`  out  1 each  output end-of-packet.
- `pkt_cnt_0`, `pkt_cnt_1`  out  `cnt_bits` each  count of packets fully delivered on each output; wraps modulo 2^`cnt_bits`.

## Operation
- **States:**
  - IDLE: no packet in progress.
  - BUSY: a packet is mid-flight on the locked route `route_q`.
- **Effective route:**
  - In IDLE, `route = sel`.
  - In BUSY, `route = route_q`.
  - `sel` changes while BUSY have no effect.
- **Accepted word** (`in_valid & in_ready`):
  - Loads `in_data`/`in_last` into output stage `route` and sets its valid bit.
  - In IDLE with `in_last = 0`: latch `route_q <= sel`, go to BUSY.
  - In IDLE with `in_last = 1`: single-word packet; stay in IDLE.
  - In BUSY with `in_last = 1`: go to IDLE.
- **Output stage k** (one register slice per output):
  - Empty when `out_valid_k = 0`.
  - Drains on `out_valid_k & out_ready_k`.
  - A simultaneous drain and load keeps valid high with the new word.
  - A drain with no load clears valid.
  - Data and last are held stable while valid is high and ready is low.
- **Input ready:** `in_ready = ~out_valid_route | out_ready_route`.
  - Combinational from the selected output's ready. This path is intentional: it gives full throughput.
  - The non-selected output never stalls the input.
- **Packet counters:** `pkt_cnt_k` increments by 1 on each output-k handshake with `out_last_k = 1`. It wraps from 2^`cnt_bits`−1 to 0.
- **Idle input:** `in_valid = 0` never changes state, `route_q` or any counter.
- **Reset** (asserted at any time, including mid-packet):
  - All in-flight words are discarded.
  - State returns to IDLE.
  - `route_q = 0`.
  - No partial-packet recovery.

## Timing
- **Reset values:** `in_ready` = 1 (both stages empty). All `out_valid_k`, `out_data_k`, `out_last_k` and `pkt_cnt_k` = 0.
- **Latency:** a word accepted at edge N appears on output `route` immediately after edge N, i.e. 1 cycle.
- **Throughput:** 1 word/cycle per packet while the selected downstream holds ready high.
- **Counter update:** `pkt_cnt_k` updates on the same edge that completes the last-word output handshake.
- **Concurrent traffic:** output 0 may still be draining packet A while the input begins packet B to output 1. The two stages are independent.
- **Back-to-back packets:** a new packet to the other output may start on the cycle after a last word is accepted; there are no bubbles.

## Structure
- **Shared package `vdp_stream_pkg`:**
  - State encoding constants: `ST_IDLE = 1'b0`, `ST_BUSY = 1'b1`.
  - Route constants: `ROUTE_0 = 1'b0`, `ROUTE_1 = 1'b1`.
- **Sub-module `stream_out_stage_nbits`** (params `bits`, `cnt_bits`):
  - Contains the valid/data/last register and the packet counter for one output.
  - Instantiated twice.
- **Top level:** holds only the FSM, `route_q` and ready steering.

## Test plan
- **Reset defaults:** hold `rst_n` low, then release. Expect `in_ready = 1` and all outputs/counters 0.
- **Basic routing:** `bits = 8`, `sel = 1`, 4-word packet 0x11..0x14 with last on 0x14, both readies high.
  - Words appear on output 1 one cycle after each accept.
  - `out_valid_0` stays 0.
  - `pkt_cnt_1 = 1`.
- **Route lock:** flip `sel` 1→0 after word 2 of a 4-word packet. All 4 words still go to output 1. The next packet goes to output 0.
- **Backpressure:** hold `out_ready_0 = 0` during a packet to output 0.
  - `in_ready` drops once stage 0 is full.
  - `out_data_0` holds stable.
  - Releasing ready resumes delivery with no loss or duplication.
- **Wrap and bypass:** `cnt_bits = 2`.
  - Send 5 single-word packets to output 0: `pkt_cnt_0` sequence 1,2,3,0,1.
  - A stalled output 1 never blocks them.
- **Reset mid-packet:** assert `rst_n` low after word 2 of a packet. All valids clear and state returns to IDLE. The next packet obeys the new `sel`.
